// File: rtl/lcd_pkg.sv
// Shared state encoding, HD44780 command bytes and ASCII constants for the
// counter display driver.
package lcd_pkg;

  typedef enum logic [3:0] {
    S_PWRUP,
    S_INIT,
    S_CLRW,
    S_FIN,
    S_SNAP,
    S_ADDR1,
    S_LINE1,
    S_ADDR2,
    S_LINE2
  } state_t;

  localparam logic [7:0] FUNC_SET = 8'h38;
  localparam logic [7:0] DISP_ON  = 8'h0C;
  localparam logic [7:0] CLEAR    = 8'h01;
  localparam logic [7:0] ENTRY    = 8'h06;
  localparam logic [7:0] LINE1    = 8'h80;
  localparam logic [7:0] LINE2    = 8'hC0;

  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] COLON = 8'h3A;
  localparam logic [7:0] QMARK = 8'h3F;
  localparam logic [7:0] ZERO  = 8'h30;

  function automatic logic [7:0] digit_char(input logic [3:0] nib);
    return (nib > 4'd9) ? QMARK : (ZERO + {4'd0, nib});
  endfunction

endpackage

// File: rtl/lcd_write_strobe.sv
// Tick-paced 3-phase LCD writer: drive rs/D, raise E, drop E. rs/D are held
// from the setup tick until the next accepted write, so they never move while E is high.
module lcd_write_strobe (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start,
  input  logic       rs_in,
  input  logic [7:0] data_in,
  output logic       ready,
  output logic       en,
  output logic       rs,
  output logic [7:0] d
);

  logic [1:0] phase_q, phase_d;
  logic       en_q, en_d;
  logic       rs_q, rs_d;
  logic [7:0] d_q, d_d;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      phase_q <= 2'd0;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      d_q     <= 8'h00;
    end else begin
      phase_q <= phase_d;
      en_q    <= en_d;
      rs_q    <= rs_d;
      d_q     <= d_d;
    end
  end

  // phase 0 idle/ready, 1 rs/D set up, 2 E high
  always_comb begin
    phase_d = phase_q;
    en_d    = en_q;
    rs_d    = rs_q;
    d_d     = d_q;
    case (phase_q)
      2'd0: if (tick && start) begin
        rs_d    = rs_in;
        d_d     = data_in;
        phase_d = 2'd1;
      end
      2'd1: if (tick) begin
        en_d    = 1'b1;
        phase_d = 2'd2;
      end
      2'd2: if (tick) begin
        en_d    = 1'b0;
        phase_d = 2'd0;
      end
      default: phase_d = 2'd0;
    endcase
  end

  assign ready = (phase_q == 2'd0);
  assign en    = en_q;
  assign rs    = rs_q;
  assign d     = d_q;

endmodule

// File: rtl/lcd_count_display_mc.sv
// HD44780 2x16 driver showing NUM_CH labelled BCD counters, 8-char fields.
// Define LCD_LZ_BLANK_EN to blank leading zero digits (least digit always shown).
//
// state   | meaning
// S_PWRUP | wait PWRUP_TICKS after reset
// S_INIT  | issue init command idx (38, 0C, 01, 06)
// S_CLRW  | let clear write finish, then CLEAR_TICKS idle ticks
// S_FIN   | let last write finish; end of init or frame_done
// S_SNAP  | latch count into snapshot
// S_ADDR1 | cmd 0x80
// S_LINE1 | 16 data writes, line 1
// S_ADDR2 | cmd 0xC0
// S_LINE2 | 16 data writes, line 2
module lcd_count_display_mc
  import lcd_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter int          DIGITS      = 4,
  parameter logic [63:0] LABELS      = "NSSNEWWE",
  parameter int          CLK_DIV     = 50000,
  parameter int          PWRUP_TICKS = 20,
  parameter int          CLEAR_TICKS = 2
) (
  input  logic                       clock,
  input  logic                       rst_n,
  input  logic [NUM_CH*4*DIGITS-1:0] count,
  output logic                       frame_done,
  output logic                       busy_init,
  output logic                       en,
  output logic                       rs,
  output logic                       rw,
  output logic [7:0]                 D
);

  localparam int CW = NUM_CH * 4 * DIGITS;
  localparam int TW = $clog2(CLK_DIV);
`ifdef LCD_LZ_BLANK_EN
  localparam bit LZ_BLANK = 1'b1;
`else
  localparam bit LZ_BLANK = 1'b0;
`endif

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;
  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic          busy_q, busy_d;
  logic          fd_q, fd_d;
  logic [CW-1:0] snap_q, snap_d;
  logic          wr_start, wr_rs, wr_ready;
  logic [7:0]    wr_data;

  // pos 0..31 -> line pos/16, col pos%16; channel fields are 8 columns wide
  function automatic logic [7:0] frame_char(input logic [4:0] pos, input logic [CW-1:0] snap);
    int         p, ch, f;
    logic [3:0] nib;
    logic       lz;
    logic [7:0] c;
    p  = int'(pos);
    ch = (p / 16) * 2 + (p % 16) / 8;
    f  = p % 8;
    c  = SPACE;
    lz = 1'b1;
    if (ch < NUM_CH) begin
      if (f == 0)      c = 8'(LABELS >> (8 * (7 - 2 * ch)));
      else if (f == 1) c = 8'(LABELS >> (8 * (6 - 2 * ch)));
      else if (f == 2) c = COLON;
      for (int j = 0; j < DIGITS; j++) begin
        nib = 4'(snap >> (4 * (ch * DIGITS + DIGITS - 1 - j)));
        if (j == f - 3)
          c = (LZ_BLANK && lz && (j != DIGITS - 1) && (nib == 4'd0)) ? SPACE : digit_char(nib);
        if (nib != 4'd0) lz = 1'b0;
      end
    end
    return c;
  endfunction

  always_comb begin
    tick       = (tick_cnt_q == TW'(CLK_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      state_q    <= S_PWRUP;
      cnt_q      <= 16'd0;
      idx_q      <= 4'd0;
      busy_q     <= 1'b1;
      fd_q       <= 1'b0;
      snap_q     <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      fd_q       <= fd_d;
      snap_q     <= snap_d;
    end
  end

  // a write is accepted on the tick where the writer is ready and start is high
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    fd_d     = 1'b0;
    snap_d   = snap_q;
    wr_start = 1'b0;
    wr_rs    = 1'b0;
    wr_data  = 8'h00;
    case (state_q)
      S_PWRUP: if (tick) begin
        if (cnt_q == 16'(PWRUP_TICKS - 1)) begin
          state_d = S_INIT;
          cnt_d   = 16'd0;
          idx_d   = 4'd0;
        end else cnt_d = cnt_q + 16'd1;
      end
      S_INIT: begin
        wr_start = 1'b1;
        case (idx_q[1:0])
          2'd0:    wr_data = FUNC_SET;
          2'd1:    wr_data = DISP_ON;
          2'd2:    wr_data = CLEAR;
          default: wr_data = ENTRY;
        endcase
        if (wr_ready && tick) begin
          cnt_d = 16'd0;
          if (idx_q == 4'd2)      state_d = S_CLRW;
          else if (idx_q == 4'd3) state_d = S_FIN;
          else                    idx_d   = idx_q + 4'd1;
        end
      end
      // two ticks finish the clear strobe, then CLEAR_TICKS idle ticks
      S_CLRW: if (tick) begin
        if (cnt_q == 16'(CLEAR_TICKS + 1)) begin
          state_d = S_INIT;
          idx_d   = 4'd3;
        end else cnt_d = cnt_q + 16'd1;
      end
      S_FIN: if (tick) begin
        if (cnt_q == 16'd1) begin
          state_d = S_SNAP;
          if (busy_q) busy_d = 1'b0;
          else        fd_d   = 1'b1;
        end else cnt_d = cnt_q + 16'd1;
      end
      S_SNAP: begin
        snap_d  = count;
        state_d = S_ADDR1;
      end
      S_ADDR1: begin
        wr_start = 1'b1;
        wr_data  = LINE1;
        if (wr_ready && tick) begin
          state_d = S_LINE1;
          idx_d   = 4'd0;
        end
      end
      S_LINE1: begin
        wr_start = 1'b1;
        wr_rs    = 1'b1;
        wr_data  = frame_char({1'b0, idx_q}, snap_q);
        if (wr_ready && tick) begin
          if (idx_q == 4'd15) state_d = S_ADDR2;
          else                idx_d   = idx_q + 4'd1;
        end
      end
      S_ADDR2: begin
        wr_start = 1'b1;
        wr_data  = LINE2;
        if (wr_ready && tick) begin
          state_d = S_LINE2;
          idx_d   = 4'd0;
        end
      end
      S_LINE2: begin
        wr_start = 1'b1;
        wr_rs    = 1'b1;
        wr_data  = frame_char({1'b1, idx_q}, snap_q);
        if (wr_ready && tick) begin
          if (idx_q == 4'd15) begin
            state_d = S_FIN;
            cnt_d   = 16'd0;
          end else idx_d = idx_q + 4'd1;
        end
      end
      default: state_d = S_PWRUP;
    endcase
  end

  lcd_write_strobe u_wr (
    .clock   (clock),
    .rst_n   (rst_n),
    .tick    (tick),
    .start   (wr_start),
    .rs_in   (wr_rs),
    .data_in (wr_data),
    .ready   (wr_ready),
    .en      (en),
    .rs      (rs),
    .d       (D)
  );

  assign frame_done = fd_q;
  assign busy_init  = busy_q;
  assign rw         = 1'b0;

endmodule
